// File: rtl/imem_boot_loader.sv
// Boot loader: assembles framed UART bytes into little-endian instruction words, writes the IMEM and
// holds the CPU in reset until a full image is in. Define LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader #(
  parameter int         ADDR_W    = 8,
  parameter int         MAX_WORDS = 256,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rstn,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [15:0]   MAX_LEN = 16'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};
`ifdef LOADER_CSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t state, state_nx;

  logic [15:0]       count_p0;
  logic [1:0]        byte_idx_p0;
  logic [23:0]       word_buf_p0;
  logic [ADDR_W:0]   word_cnt_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic              cpu_rstn_q;
  logic              load_done_q;
  logic              load_err_q;

  logic [15:0] len_full;
  logic [15:0] word_cnt_nx;
  logic        last_word;
  logic        hdr_start;
  logic        enter_done;
  logic        enter_err;

`ifdef LOADER_CSUM_EN
  logic [7:0] csum_p0;
`endif

  assign len_full    = {rx_data, count_p0[7:0]};
  assign word_cnt_nx = 16'(word_cnt_p0) + 16'd1;
  assign last_word   = (word_cnt_nx == count_p0);
  assign hdr_start   = rx_valid && (state inside {IDLE, DONE, ERR}) && (rx_data == HDR_BYTE);
  assign enter_done  = rx_valid && (state != DONE) && (state_nx == DONE);
  assign enter_err   = rx_valid && (state != ERR) && (state_nx == ERR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rx_valid) begin
      case (state)
        IDLE, DONE, ERR: if (rx_data == HDR_BYTE) state_nx = LEN0;
        LEN0: state_nx = LEN1;
        LEN1: begin
          if (len_full > MAX_LEN)  state_nx = ERR;
          else if (len_full == '0) state_nx = END_ST;
          else                     state_nx = DATA;
        end
        // A header byte here is payload, never a restart
        DATA: if (byte_idx_p0 == 2'd3 && last_word) state_nx = END_ST;
`ifdef LOADER_CSUM_EN
        CSUM: state_nx = (rx_data == csum_p0) ? DONE : ERR;
`else
        CSUM: state_nx = IDLE;
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  // p0: byte capture / word assembly -> p1: IMEM write strobe and status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_p0    <= '0;
      byte_idx_p0 <= '0;
      word_buf_p0 <= '0;
      word_cnt_p0 <= '0;
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
      wdata_p1    <= '0;
      cpu_rstn_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (hdr_start) begin
        cpu_rstn_q  <= 1'b0;
        load_done_q <= 1'b0;
        load_err_q  <= 1'b0;
        word_cnt_p0 <= '0;
      end
      if (enter_done) begin
        cpu_rstn_q  <= 1'b1;
        load_done_q <= 1'b1;
      end
      if (enter_err) load_err_q <= 1'b1;
      if (rx_valid) begin
        case (state)
          LEN0: count_p0[7:0] <= rx_data;
          LEN1: begin
            count_p0[15:8] <= rx_data;
            byte_idx_p0    <= '0;
            word_cnt_p0    <= '0;
          end
          DATA: begin
            byte_idx_p0 <= byte_idx_p0 + 2'd1;
            if (byte_idx_p0 == 2'd3) begin
              vld_p1      <= 1'b1;
              addr_p1     <= word_cnt_p0[ADDR_W-1:0];
              wdata_p1    <= {rx_data, word_buf_p0};
              word_cnt_p0 <= word_cnt_p0 + ONE_W;
            end else begin
              word_buf_p0[8*byte_idx_p0 +: 8] <= rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                            csum_p0 <= '0;
    else if (hdr_start)                                   csum_p0 <= '0;
    else if (rx_valid && (state inside {LEN0, LEN1, DATA})) csum_p0 <= csum_p0 ^ rx_data;
  end
`endif

  assign im_we        = vld_p1;
  assign im_addr      = addr_p1;
  assign im_wdata     = wdata_p1;
  assign cpu_rstn     = cpu_rstn_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = word_cnt_p0;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle RISC-V computer's instruction memory.
- Takes a framed byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction ROM write port.
- Holds the CPU in reset until a complete, valid image is loaded, then releases it so execution starts at PC 0.

Parameters:
- ADDR_W, 8, instruction memory word-address width (256 words).
- MAX_WORDS, 256, largest word count accepted in a frame. Must be ≤ 2^ADDR_W.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- im_we  out  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  out  ADDR_W  word address for the write.
- im_wdata  out  32  instruction word.
- cpu_rstn  out  1  active-low reset to the CPU core.
- load_done  out  1  high while the loaded image is valid and the CPU is running.
- load_err  out  1  high after a failed frame, until the next header.
- words_loaded  out  ADDR_W+1  number of words written in the current or last frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: state=IDLE; im_we=0; im_addr=0; im_wdata=0; cpu_rstn=0; load_done=0; load_err=0; words_loaded=0. Reset mid-frame aborts the frame and returns to IDLE.
- Byte acceptance: a byte is consumed on every clk edge where rx_valid=1. There is no backpressure. Bytes with rx_valid=0 are ignored.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE:
  - rx_data==HDR_BYTE → LEN0, cpu_rstn=0.
  - Any other byte is discarded.
- LEN0: capture count[7:0] → LEN1.
- LEN1: capture count[15:8].
  - count > MAX_WORDS → ERR.
  - count == 0 → CSUM if LOADER_CSUM_EN is defined, else DONE.
  - Otherwise → DATA. Clear the byte index and word index.
- DATA:
  - Byte k of a word goes to bits [8k+7:8k] (little-endian).
  - On the 4th byte, next cycle: im_we=1 for exactly one cycle, im_addr=word index, im_wdata=assembled word. Word index and words_loaded then increment.
  - After the last word → CSUM (macro defined) or DONE.
- CSUM: see Optional Feature.
- DONE:
  - cpu_rstn=1 and load_done=1 starting the cycle after entry.
  - A HDR_BYTE byte → LEN0: cpu_rstn=0, load_done=0, words_loaded=0 in the same edge.
  - Other bytes are ignored, since the running program may itself use the UART.
- ERR:
  - load_err=1, cpu_rstn stays 0.
  - Words already written are not rolled back.
  - A HDR_BYTE byte → LEN0 and clears load_err.
- Header during DATA: treated as data, never as a restart.
- Word address: wraps only if MAX_WORDS = 2^ADDR_W. The count check guarantees no overflow.
- Latency: last byte of a word → im_we pulse is 1 cycle. Final accepted byte → cpu_rstn high is 1 cycle.
- Back-to-back rx_valid on consecutive cycles: fully supported. The im_we pulse overlaps assembly of the next word.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- Defined:
  - Each frame ends with one checksum byte: the XOR of every byte after the header (both length bytes and all data bytes).
  - In CSUM, match → DONE; mismatch → ERR.
- Not defined:
  - No checksum byte is expected; the frame ends with the last data byte → DONE.
  - The XOR accumulator logic is absent.

Test Plan:
- Reset: hold rstn=0 mid-DATA → all outputs at reset values, state IDLE. Release, send a full frame → loads normally.
- Checksum frame (LOADER_CSUM_EN defined): send A5 02 00 93 00 50 00 13 01 A0 00 73.
  - im_we pulses twice: addr 0 / 0x00500093, then addr 1 / 0x00A00113.
  - words_loaded=2, then cpu_rstn=1 and load_done=1.
- Same frame with last byte 0x74 → load_err=1, cpu_rstn=0, both words still written. Then send the correct frame → load_done=1, load_err=0.
- Junk and idle gaps: send 00 FF 3C before A5, and rx_valid gaps of 0–5 cycles between bytes → junk ignored, same writes as the checksum frame.
- Limits: length 01 01 (257) → ERR immediately, no im_we. Length 00 00 → DONE with no writes, words_loaded=0.
- Reload: in DONE, send A5 → cpu_rstn drops the next cycle, load_done=0, and a new frame overwrites from addr 0.
